// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: per-axis timing description and derived region boundaries.
package vga_timing_pkg;
  typedef struct packed {
    int disp;
    int front;
    int sync;
    int back;
  } timing_t;
  function automatic int total(timing_t t);
    return t.disp + t.front + t.sync + t.back;
  endfunction
  function automatic int sync_start(timing_t t);
    return t.disp + t.front;
  endfunction
endpackage

// File: rtl/timing_axis.sv
// timing_axis: one raster counter with wrap flag and registered display/sync decode.
module timing_axis
  import vga_timing_pkg::*;
#(
  parameter int DISP  = 640,
  parameter int FRONT = 16,
  parameter int SYNC  = 96,
  parameter int BACK  = 48,
  parameter int CW    = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_adv,
  output logic [CW-1:0] o_cnt,
  output logic          o_wrap,
  output logic          o_in_disp,
  output logic          o_in_sync
);
  localparam timing_t T   = timing_t'{disp: DISP, front: FRONT, sync: SYNC, back: BACK};
  localparam int      TOT = total(T);
  localparam int      SS  = sync_start(T);
  logic [CW-1:0] r_cnt, w_nxt;
  logic          r_in_disp, r_in_sync;
  assign o_wrap = r_cnt == CW'(TOT - 1);
  always_comb w_nxt = o_wrap ? '0 : r_cnt + CW'(1);
  // Decode the value being loaded so the flags line up with the count, no extra latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= CW'(TOT - 1);
      r_in_disp <= 1'b0;
      r_in_sync <= 1'b0;
    end else if (i_adv) begin
      r_cnt     <= w_nxt;
      r_in_disp <= w_nxt < CW'(DISP);
      r_in_sync <= (w_nxt >= CW'(SS)) && (w_nxt < CW'(SS + SYNC));
    end
  end
  assign o_cnt     = r_cnt;
  assign o_in_disp = r_in_disp;
  assign o_in_sync = r_in_sync;
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: two-axis raster timing with polarity-configurable syncs and line/frame strobes.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_DISP  = 640,
  parameter int H_FRONT = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BACK  = 48,
  parameter int V_DISP  = 480,
  parameter int V_FRONT = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BACK  = 33,
  parameter int HS_POL  = 0,
  parameter int VS_POL  = 0,
  parameter int CW      = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start
);
  localparam int H_TOTAL = total(timing_t'{disp: H_DISP, front: H_FRONT, sync: H_SYNC, back: H_BACK});
  localparam int V_TOTAL = total(timing_t'{disp: V_DISP, front: V_FRONT, sync: V_SYNC, back: V_BACK});
  if (H_DISP < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
      V_DISP < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1) begin : g_bad_len
    $error("vga_timing_gen: every display/porch/sync length must be at least 1");
  end
  if (CW < 1 || CW > 30 || H_TOTAL > (1 << CW) || V_TOTAL > (1 << CW)) begin : g_bad_cw
    $error("vga_timing_gen: H_TOTAL or V_TOTAL does not fit in CW bits");
  end
  if (!(HS_POL inside {0, 1}) || !(VS_POL inside {0, 1})) begin : g_bad_pol
    $error("vga_timing_gen: HS_POL and VS_POL must be 0 or 1");
  end
  logic w_hwrap, w_vwrap, w_hdisp, w_vdisp, w_hsync, w_vsync;
  logic r_line_start, r_frame_start;
  timing_axis #(.DISP(H_DISP), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK), .CW(CW)) u_h (
    .clk(clk), .rst(rst), .i_adv(ce),
    .o_cnt(x), .o_wrap(w_hwrap), .o_in_disp(w_hdisp), .o_in_sync(w_hsync)
  );
  timing_axis #(.DISP(V_DISP), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK), .CW(CW)) u_v (
    .clk(clk), .rst(rst), .i_adv(ce & w_hwrap),
    .o_cnt(y), .o_wrap(w_vwrap), .o_in_disp(w_vdisp), .o_in_sync(w_vsync)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_line_start  <= ce & w_hwrap;
      r_frame_start <= ce & w_hwrap & w_vwrap;
    end
  end
  assign de          = w_hdisp & w_vdisp;
  assign hsync       = w_hsync ? HS_POL[0] : ~HS_POL[0];
  assign vsync       = w_vsync ? VS_POL[0] : ~VS_POL[0];
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for a 29x8 raster with both sync polarity variants.
module tb_vga_timing_gen;
  localparam int CW = 6;
  logic clk = 1'b0, rst = 1'b1, ce = 1'b0;
  logic hs_a, vs_a, de_a, ls_a, fs_a, hs_b, vs_b, de_b, ls_b, fs_b;
  logic [CW-1:0] x_a, y_a, x_b, y_b;
  always #5 clk = ~clk;
  vga_timing_gen #(.H_DISP(15), .H_FRONT(1), .H_SYNC(3), .H_BACK(10),
                   .V_DISP(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
                   .HS_POL(0), .VS_POL(1), .CW(CW)) dut_a (
    .clk(clk), .rst(rst), .ce(ce), .hsync(hs_a), .vsync(vs_a), .de(de_a),
    .x(x_a), .y(y_a), .line_start(ls_a), .frame_start(fs_a));
  vga_timing_gen #(.H_DISP(15), .H_FRONT(1), .H_SYNC(3), .H_BACK(10),
                   .V_DISP(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
                   .HS_POL(1), .VS_POL(0), .CW(CW)) dut_b (
    .clk(clk), .rst(rst), .ce(ce), .hsync(hs_b), .vsync(vs_b), .de(de_b),
    .x(x_b), .y(y_b), .line_start(ls_b), .frame_start(fs_b));
  typedef struct {
    logic [16:0] v;
    bit          rr;
    int          lp;
    int          fp;
  } exp_t;
  exp_t q[$];
  int n_pass = 0, n_tot = 0;
  int mx = 28, my = 7;
  logic mls = 1'b0, mfs = 1'b0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tot++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
  endtask
  // Reference raster: region boundaries written out by hand for 15/1/3/10 x 4/1/2/1.
  task automatic cyc(input logic c, input logic r, input int lp, input int fp);
    exp_t e;
    logic wrap;
    ce  = c;
    rst = r;
    @(posedge clk);
    if (r) begin
      mx = 28; my = 7; mls = 1'b0; mfs = 1'b0;
    end else if (c) begin
      wrap = mx == 28;
      mx   = wrap ? 0 : mx + 1;
      if (wrap) my = (my == 7) ? 0 : my + 1;
      mls  = wrap;
      mfs  = wrap && my == 0;
    end else begin
      mls = 1'b0; mfs = 1'b0;
    end
    e.v  = {6'(mx), 6'(my), (mx < 15 && my < 4), !(mx >= 16 && mx <= 18),
            (my >= 5 && my <= 6), mls, mfs};
    e.rr = r;
    e.lp = lp;
    e.fp = fp;
    q.push_back(e);
    #1;
  endtask
  int cyc_n = 0, last_ls = -1, last_fs = -1;
  always @(negedge clk) begin
    exp_t e;
    cyc_n++;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("main", 32'({x_a, y_a, de_a, hs_a, vs_a, ls_a, fs_a}), 32'(e.v));
      chk("inverted_pol", 32'({x_b, y_b, de_b, ~hs_b, ~vs_b, ls_b, fs_b}), 32'(e.v));
      if (e.rr) begin
        last_ls = -1;
        last_fs = -1;
      end
      if (ls_a) begin
        if (last_ls >= 0) chk("line_period", 32'(cyc_n - last_ls), 32'(e.lp));
        last_ls = cyc_n;
      end
      if (fs_a) begin
        if (last_fs >= 0) chk("frame_period", 32'(cyc_n - last_fs), 32'(e.fp));
        last_fs = cyc_n;
      end
    end
  end
  initial begin
    int guard;
    cyc(0, 1, 29, 232);
    cyc(0, 1, 29, 232);
    cyc(1, 1, 29, 232);
    for (int i = 0; i < 2 * 232 + 3; i++) cyc(1, 0, 29, 232);
    cyc(0, 1, 87, 696);
    for (int i = 0; i < 2 * 232 + 2; i++) begin
      cyc(1, 0, 87, 696);
      cyc(0, 0, 87, 696);
      cyc(0, 0, 87, 696);
    end
    cyc(0, 1, 29, 232);
    guard = 0;
    while (!(mx == 20 && my == 3) && guard < 400) begin
      cyc(1, 0, 29, 232);
      guard++;
    end
    chk("reach_x20_y3", 32'(guard < 400), 32'd1);
    cyc(1, 1, 29, 232);
    for (int i = 0; i < 40; i++) cyc(1, 0, 29, 232);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
